// File: rtl/right_shift_seq.sv
// ---------------------------------------------------------------------------
// right_shift_seq
//   Multi-cycle right shifter for the ALU datapath. Operand A is shifted right
//   by C (unsigned, saturating at WIDTH), logically or arithmetically. The
//   iterative datapath shifts one bit per clock. Result B and flags Z/N are
//   registered and stay put until the next operation completes.
//
//   Build option:
//     RSHIFT_BARREL_EN  - replace the iterative shift with a combinational
//                         barrel shifter; every op finishes one cycle after
//                         start. Results are identical, only timing differs.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   asynchronous active-high reset
//     start  in   launch request, sampled only while idle
//     arith  in   1 = sign fill, 0 = zero fill (latched with start)
//     A      in   operand (latched with start)
//     C      in   shift amount, unsigned (latched with start)
//     B      out  registered result
//     Z      out  registered, B == 0
//     N      out  registered, B[WIDTH-1]
//     busy   out  high while an op is in flight (SHIFT or DONE)
//     done   out  one-cycle pulse when B/Z/N are valid
// ---------------------------------------------------------------------------
module right_shift_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] A,
    input  logic [31:0]      C,
    output logic [WIDTH-1:0] B,
    output logic             Z,
    output logic             N,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] amt;
    logic             arith_q, arith_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    logic             load_out;

    // C is unsigned 32-bit, so "negative" amounts land here and saturate.
    always_comb begin
        if (C >= 32'(WIDTH)) amt = CNT_W'(WIDTH);
        else                 amt = C[CNT_W-1:0];
    end

`ifdef RSHIFT_BARREL_EN
    // Sign/zero-extend to double width, then shift; an amount of WIDTH
    // leaves only fill bits, which is exactly the saturated result.
    logic [WIDTH-1:0] bar;
    always_comb begin
        bar = WIDTH'({{WIDTH{arith & A[WIDTH-1]}}, A} >> amt);
    end
`endif

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        arith_d  = arith_q;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    arith_d = arith;
`ifdef RSHIFT_BARREL_EN
                    work_d   = bar;
                    cnt_d    = '0;
                    state_d  = DONE;
                    load_out = 1'b1;
`else
                    work_d = A;
                    cnt_d  = amt;
                    if (amt != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = DONE;
                        load_out = 1'b1;
                    end
`endif
                end
            end
            SHIFT: begin
                work_d = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs capture the final working value on the edge entering DONE.
    always_comb begin
        b_d = b_q;
        z_d = z_q;
        n_d = n_q;
        if (load_out) begin
            b_d = work_d;
            z_d = (work_d == '0);
            n_d = work_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            arith_q <= 1'b0;
            b_q     <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            arith_q <= arith_d;
            b_q     <= b_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign B    = b_q;
    assign Z    = z_q;
    assign N    = n_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_right_shift_seq.sv
module tb_right_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        arith;
    logic [31:0] A;
    logic [31:0] C;
    logic [31:0] B;
    logic        Z, N, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    right_shift_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .arith(arith),
        .A(A), .C(C), .B(B), .Z(Z), .N(N), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: saturate amount, then plain shift arithmetic.
    function automatic logic [31:0] ref_rs(input logic [31:0] a, input logic [31:0] c,
                                           input logic ar);
        int unsigned       amt;
        logic signed [31:0] s;
        amt = (c >= 32) ? 32 : c;
        if (amt == 32) return (ar && a[31]) ? 32'hFFFF_FFFF : 32'h0;
        if (ar) begin
            s = a;
            s = s >>> amt;
            return s;
        end
        return a >> amt;
    endfunction

    function automatic int ref_lat(input logic [31:0] c);
`ifdef RSHIFT_BARREL_EN
        return 0;
`else
        return (c >= 32) ? 32 : int'(c);
`endif
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns likewise.
    task automatic run_op(input logic [31:0] a, input logic [31:0] c, input logic ar,
                          input string tag);
        logic [31:0] exp_b;
        int          lat;
        exp_b = ref_rs(a, c, ar);
        A = a; C = c; arith = ar; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; C = $urandom; arith = 1'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(ref_lat(c)));
        chk({tag, "_B"}, B, exp_b);
        chk({tag, "_Z"}, 32'(Z), 32'(exp_b == 32'h0));
        chk({tag, "_N"}, 32'(N), 32'(exp_b[31]));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_B_hold"}, B, exp_b);
    endtask

    initial begin
        int          ndone;
        logic [31:0] a0, c_r;
        rst = 1'b1; start = 1'b0; arith = 1'b0; A = '0; C = '0;
        #12;
        chk("rst_B", B, 32'h0);
        chk("rst_Z", 32'(Z), 32'd1);
        chk("rst_N", 32'(N), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        run_op(32'h0001_0000, 32'd1, 1'b0, "d_log1");
        run_op(32'hEFFF_0000, 32'd1, 1'b1, "d_ari1");
        run_op(32'hEFFF_0000, 32'd1, 1'b0, "d_log1n");
        run_op(32'h0010_1010, 32'hFFFF_FFFF, 1'b0, "d_satL");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "d_satA");
        run_op(32'h1234_5678, 32'd0, 1'b0, "d_zero");
        run_op(32'h8000_0001, 32'd31, 1'b1, "d_31");
        run_op(32'h8000_0001, 32'd32, 1'b0, "d_32");

        // Second start while busy is dropped
        a0 = 32'hA5C3_0F81;
        A = a0; C = 32'd8; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        A = 32'h0; C = 32'd0; start = 1'b1;   // op in flight: must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                chk("ign_B", B, a0 >> 8);
            end
            @(posedge clk); #1;
        end
        chk("ign_ndone", 32'(ndone), 32'd1);

        // Asynchronous reset mid-operation
        A = 32'hFFFF_0000; C = 32'd20; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        chk("arst_B", B, 32'h0);
        chk("arst_Z", 32'(Z), 32'd1);
        chk("arst_N", 32'(N), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("arst_nodone", 32'(ndone), 32'd0);
        run_op(32'h0F0F_F0F0, 32'd4, 1'b0, "post_rst");

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       c_r = $urandom;
                1:       c_r = $urandom_range(30, 34);
                default: c_r = $urandom_range(0, 31);
            endcase
            run_op($urandom, c_r, 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
